// File: rtl/iagc_gain_controller.sv
// IAGC loop sequencer: times reference/error measurement windows in sample edges,
// latches the detector amplitudes and hill-climbs a saturating gain word to convergence.
module iagc_gain_controller #(
    parameter int IAGC_STATUS_SIZE     = 4,
    parameter int SAMPLER_DATA_SIZE    = 16,
    parameter int AMPLITUDE_COUNT_SIZE = 16,
    parameter int GAIN_SIZE            = 8,
    parameter int ITER_SIZE            = 8,
    parameter int SETTLE_CYCLES        = 16
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_start,
    input  logic                            i_sample,
    input  logic [AMPLITUDE_COUNT_SIZE-1:0] i_amplitude_count,
    input  logic [SAMPLER_DATA_SIZE-1:0]    i_reference_amplitude,
    input  logic [SAMPLER_DATA_SIZE-1:0]    i_error_amplitude,
    input  logic [SAMPLER_DATA_SIZE-1:0]    i_tolerance,
    input  logic [GAIN_SIZE-1:0]            i_gain_init,
    input  logic [GAIN_SIZE-1:0]            i_gain_step,
    input  logic [ITER_SIZE-1:0]            i_max_iterations,
    output logic [IAGC_STATUS_SIZE-1:0]     o_iagc_status,
    output logic [GAIN_SIZE-1:0]            o_gain,
    output logic [SAMPLER_DATA_SIZE-1:0]    o_reference_latched,
    output logic [SAMPLER_DATA_SIZE-1:0]    o_error_latched,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_fail
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [IAGC_STATUS_SIZE-1:0] {
        ST_IDLE     = IAGC_STATUS_SIZE'(0),
        ST_MEAS_REF = IAGC_STATUS_SIZE'(1),
        ST_MEAS_ERR = IAGC_STATUS_SIZE'(2),
        ST_ADJUST   = IAGC_STATUS_SIZE'(3),
        ST_SETTLE   = IAGC_STATUS_SIZE'(4),
        ST_DONE     = IAGC_STATUS_SIZE'(5),
        ST_FAIL     = IAGC_STATUS_SIZE'(6)
    } state_t;

    // Result MSB flags a clamp; lower bits are the saturated gain.
    function automatic logic [GAIN_SIZE:0] sat_step(input logic [GAIN_SIZE-1:0] gain,
                                                    input logic [GAIN_SIZE-1:0] step,
                                                    input logic             up);
        logic [GAIN_SIZE:0] ext;
        if (up) begin
            ext = {1'b0, gain} + {1'b0, step};
            sat_step = ext[GAIN_SIZE] ? {1'b1, {GAIN_SIZE{1'b1}}} : ext;
        end else begin
            ext = {1'b0, gain} - {1'b0, step};
            sat_step = ext[GAIN_SIZE] ? {1'b1, {GAIN_SIZE{1'b0}}} : ext;
        end
    endfunction

    state_t                          state_r, state_s;
    logic                            sample_r;
    logic [AMPLITUDE_COUNT_SIZE-1:0] win_cnt_r;
    logic [SETTLE_W-1:0]             settle_cnt_r;
    logic                            dir_up_r;
    logic [ITER_SIZE-1:0]            iter_r;
    logic [SAMPLER_DATA_SIZE-1:0]    prev_err_r;

    logic                            edge_s;
    logic [AMPLITUDE_COUNT_SIZE:0]   win_next_s;
    logic [AMPLITUDE_COUNT_SIZE:0]   win_target_s;
    logic                            win_done_s;
    logic                            settle_done_s;
    logic                            converged_s;
    logic                            exhausted_s;
    logic                            dir_s;
    logic [GAIN_SIZE:0]              step_res_s;

    assign o_iagc_status = state_r;

    // Window/settle progress and the hill-climb step for the ADJUST cycle.
    always_comb begin
        edge_s       = i_sample & ~sample_r;
        win_next_s   = {1'b0, win_cnt_r} + (AMPLITUDE_COUNT_SIZE+1)'(1);
        if (i_amplitude_count == AMPLITUDE_COUNT_SIZE'(0)) begin
            win_target_s = (AMPLITUDE_COUNT_SIZE+1)'(1);
        end else begin
            win_target_s = {1'b0, i_amplitude_count};
        end
        win_done_s    = edge_s && (win_next_s >= win_target_s);
        settle_done_s = (settle_cnt_r >= SETTLE_W'(SETTLE_CYCLES));
        converged_s   = (o_error_latched <= i_tolerance);
        exhausted_s   = (iter_r == i_max_iterations);
        dir_s         = dir_up_r ^ (o_error_latched > prev_err_r);
        step_res_s    = sat_step(o_gain, i_gain_step, dir_s);
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (i_start) state_s = ST_MEAS_REF;
                else         state_s = state_r;
            end
            ST_MEAS_REF: begin
                if (win_done_s) state_s = ST_MEAS_ERR;
                else            state_s = ST_MEAS_REF;
            end
            ST_MEAS_ERR: begin
                if (win_done_s) state_s = ST_ADJUST;
                else            state_s = ST_MEAS_ERR;
            end
            ST_ADJUST: begin
                if (converged_s)      state_s = ST_DONE;
                else if (exhausted_s) state_s = ST_FAIL;
                else                  state_s = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_done_s) state_s = ST_MEAS_REF;
                else               state_s = ST_SETTLE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, datapath and registered flag outputs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r             <= ST_IDLE;
            sample_r            <= 1'b0;
            win_cnt_r           <= AMPLITUDE_COUNT_SIZE'(0);
            settle_cnt_r        <= SETTLE_W'(0);
            dir_up_r            <= 1'b1;
            iter_r              <= ITER_SIZE'(0);
            prev_err_r          <= {SAMPLER_DATA_SIZE{1'b1}};
            o_gain              <= GAIN_SIZE'(0);
            o_reference_latched <= SAMPLER_DATA_SIZE'(0);
            o_error_latched     <= SAMPLER_DATA_SIZE'(0);
            o_busy              <= 1'b0;
            o_done              <= 1'b0;
            o_fail              <= 1'b0;
        end else begin
            state_r  <= state_s;
            sample_r <= i_sample;
            o_busy   <= !(state_s == ST_IDLE || state_s == ST_DONE || state_s == ST_FAIL);
            o_done   <= (state_s == ST_DONE);
            o_fail   <= (state_s == ST_FAIL);
            case (state_r)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (i_start) begin
                        o_gain     <= i_gain_init;
                        iter_r     <= ITER_SIZE'(0);
                        dir_up_r   <= 1'b1;
                        prev_err_r <= {SAMPLER_DATA_SIZE{1'b1}};
                        win_cnt_r  <= AMPLITUDE_COUNT_SIZE'(0);
                    end
                end
                ST_MEAS_REF: begin
                    if (win_done_s) begin
                        o_reference_latched <= i_reference_amplitude;
                        win_cnt_r           <= AMPLITUDE_COUNT_SIZE'(0);
                    end else if (edge_s) begin
                        win_cnt_r <= win_next_s[AMPLITUDE_COUNT_SIZE-1:0];
                    end
                end
                ST_MEAS_ERR: begin
                    if (win_done_s) begin
                        o_error_latched <= i_error_amplitude;
                        win_cnt_r       <= AMPLITUDE_COUNT_SIZE'(0);
                    end else if (edge_s) begin
                        win_cnt_r <= win_next_s[AMPLITUDE_COUNT_SIZE-1:0];
                    end
                end
                ST_ADJUST: begin
                    if (!converged_s && !exhausted_s) begin
                        o_gain       <= step_res_s[GAIN_SIZE-1:0];
                        dir_up_r     <= dir_s ^ step_res_s[GAIN_SIZE];
                        prev_err_r   <= o_error_latched;
                        iter_r       <= iter_r + ITER_SIZE'(1);
                        settle_cnt_r <= SETTLE_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_done_s) begin
                        win_cnt_r <= AMPLITUDE_COUNT_SIZE'(0);
                    end else begin
                        settle_cnt_r <= settle_cnt_r + SETTLE_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iagc_gain_controller.sv
// Bench for iagc_gain_controller: vector table, hand-written window/reset sequences and
// randomized runs checked against an iteration-level model of the gain hill-climb.
module tb_iagc_gain_controller;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic        i_sample;
    logic [15:0] i_amplitude_count;
    logic [15:0] i_reference_amplitude;
    logic [15:0] i_error_amplitude;
    logic [15:0] i_tolerance;
    logic [7:0]  i_gain_init;
    logic [7:0]  i_gain_step;
    logic [7:0]  i_max_iterations;
    logic [3:0]  o_iagc_status;
    logic [7:0]  o_gain;
    logic [15:0] o_reference_latched;
    logic [15:0] o_error_latched;
    logic        o_busy;
    logic        o_done;
    logic        o_fail;

    iagc_gain_controller dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_sample(i_sample),
        .i_amplitude_count(i_amplitude_count), .i_reference_amplitude(i_reference_amplitude),
        .i_error_amplitude(i_error_amplitude), .i_tolerance(i_tolerance),
        .i_gain_init(i_gain_init), .i_gain_step(i_gain_step),
        .i_max_iterations(i_max_iterations), .o_iagc_status(o_iagc_status), .o_gain(o_gain),
        .o_reference_latched(o_reference_latched), .o_error_latched(o_error_latched),
        .o_busy(o_busy), .o_done(o_done), .o_fail(o_fail)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        int gi, step, mi, tol, cnt;
        int e0, e1, e2, e3, n;
        int x_state, x_gain, x_steps;
    } vec_t;

    vec_t tab[7];
    int   err_tab[8];
    int   n_err;
    int   exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ph = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge i_clock);
    endtask

    task automatic pulse;
        i_sample = 1'b1;
        tick;
        i_sample = 1'b0;
        tick;
    endtask

    // Iteration-level model: one pass per ADJUST, plain signed arithmetic with clamping.
    task automatic model(input int gi, input int st, input int mi, input int tol,
                         output int xs, output int xg, output int xn);
        int g, dir, prev, k, e, ng;
        g = gi; dir = 1; prev = 65535; k = 0;
        exp_q.delete();
        forever begin
            e = err_tab[(k < n_err) ? k : n_err - 1];
            if (e <= tol) begin xs = 5; break; end
            if (k == mi) begin xs = 6; break; end
            if (e > prev) dir = -dir;
            ng = g + dir * st;
            if (ng > 255) begin ng = 255; dir = -dir; end
            else if (ng < 0) begin ng = 0; dir = -dir; end
            g = ng;
            exp_q.push_back(g);
            prev = e;
            k++;
        end
        xg = g;
        xn = k;
    endtask

    task automatic run(input int gi, input int st, input int mi, input int tol, input int cnt,
                       input int refv, input int xs, input int xg, input int xn);
        int prev_st, cur, k, xe;
        bit fin, seen_err;
        i_gain_init = 8'(gi); i_gain_step = 8'(st); i_max_iterations = 8'(mi);
        i_tolerance = 16'(tol); i_amplitude_count = 16'(cnt);
        i_reference_amplitude = 16'(refv); i_error_amplitude = 16'(err_tab[0]);
        i_start = 1'b1;
        tick;
        i_start = 1'b0;
        chk("start_status", int'(o_iagc_status), 1);
        prev_st = 1; cur = 1; k = 0; fin = 1'b0; seen_err = 1'b0;
        for (int c = 0; c < 4000 && !fin; c++) begin
            ph++;
            i_sample = ph[1];
            i_error_amplitude = 16'(err_tab[(k < n_err) ? k : n_err - 1]);
            tick;
            cur = int'(o_iagc_status);
            if (cur == 2) seen_err = 1'b1;
            if (prev_st == 3 && cur == 4) begin
                chk("step_gain", int'(o_gain), (k < exp_q.size()) ? exp_q[k] : -1);
                k++;
            end
            if (cur == 5 || cur == 6) fin = 1'b1;
            prev_st = cur;
        end
        if (!fin) chk("run_timeout_status", cur, xs);
        xe = err_tab[(xn < n_err) ? xn : n_err - 1];
        chk("meas_err_seen", int'(seen_err), 1);
        chk("final_status", int'(o_iagc_status), xs);
        chk("final_done", int'(o_done), (xs == 5) ? 1 : 0);
        chk("final_fail", int'(o_fail), (xs == 6) ? 1 : 0);
        chk("final_busy", int'(o_busy), 0);
        chk("final_gain", int'(o_gain), xg);
        chk("gain_changes", k, xn);
        chk("err_latched", int'(o_error_latched), xe);
        chk("ref_latched", int'(o_reference_latched), refv);
        repeat (5) begin ph++; i_sample = ph[1]; tick; end
        chk("hold_status", int'(o_iagc_status), xs);
        chk("hold_gain", int'(o_gain), xg);
    endtask

    initial begin
        int xs, xg, xn, n;
        tab[0] = '{50, 5, 10, 20, 4, 10, 0, 0, 0, 1, 5, 50, 0};
        tab[1] = '{50, 5, 10, 40, 4, 80, 60, 70, 30, 4, 5, 55, 3};
        tab[2] = '{253, 5, 2, 10, 1, 500, 0, 0, 0, 1, 6, 250, 2};
        tab[3] = '{50, 5, 2, 10, 2, 500, 0, 0, 0, 1, 6, 60, 2};
        tab[4] = '{50, 5, 0, 10, 0, 500, 0, 0, 0, 1, 6, 50, 0};
        tab[5] = '{3, 5, 3, 10, 0, 90, 100, 0, 0, 2, 6, 0, 3};
        tab[6] = '{50, 0, 3, 10, 3, 500, 0, 0, 0, 1, 6, 50, 3};

        i_reset = 1'b0; i_start = 1'b0; i_sample = 1'b0;
        i_amplitude_count = 16'd0; i_reference_amplitude = 16'd0; i_error_amplitude = 16'd0;
        i_tolerance = 16'd0; i_gain_init = 8'd0; i_gain_step = 8'd0; i_max_iterations = 8'd0;
        tick; tick;
        chk("rst_status", int'(o_iagc_status), 0);
        chk("rst_gain", int'(o_gain), 0);
        chk("rst_flags", int'({o_busy, o_done, o_fail}), 0);
        chk("rst_latches", int'(o_reference_latched) + int'(o_error_latched), 0);
        i_reset = 1'b1;
        tick;
        chk("idle_after_rst", int'(o_iagc_status), 0);

        for (int i = 0; i < 7; i++) begin
            err_tab[0] = tab[i].e0; err_tab[1] = tab[i].e1;
            err_tab[2] = tab[i].e2; err_tab[3] = tab[i].e3;
            n_err = tab[i].n;
            model(tab[i].gi, tab[i].step, tab[i].mi, tab[i].tol, xs, xg, xn);
            run(tab[i].gi, tab[i].step, tab[i].mi, tab[i].tol, tab[i].cnt, 100 + i,
                tab[i].x_state, tab[i].x_gain, tab[i].x_steps);
        end

        // Window counting: start ignored mid-window, live count shrink, settle length, count=0.
        i_sample = 1'b0; i_amplitude_count = 16'd4; i_gain_init = 8'd77; i_gain_step = 8'd3;
        i_max_iterations = 8'd9; i_tolerance = 16'd0; i_error_amplitude = 16'd300;
        i_reference_amplitude = 16'd1234;
        tick;
        i_start = 1'b1; tick; i_start = 1'b0;
        chk("hs_start", int'(o_iagc_status), 1);
        pulse; pulse;
        i_start = 1'b1; tick; i_start = 1'b0;
        pulse;
        chk("start_ignored_open", int'(o_iagc_status), 1);
        pulse;
        chk("window_4_edges", int'(o_iagc_status), 2);
        chk("hs_ref_latched", int'(o_reference_latched), 1234);
        pulse; pulse;
        chk("err_window_open", int'(o_iagc_status), 2);
        i_amplitude_count = 16'd1;
        i_sample = 1'b1; tick;
        chk("shrunk_window_adjust", int'(o_iagc_status), 3);
        chk("hs_err_latched", int'(o_error_latched), 300);
        i_sample = 1'b0; tick;
        n = 0;
        while (o_iagc_status == 4'd4 && n < 100) begin n++; tick; end
        chk("settle_cycles", n, 16);
        chk("after_settle", int'(o_iagc_status), 1);
        chk("hs_gain", int'(o_gain), 80);
        i_amplitude_count = 16'd0;
        tick; tick;
        chk("count0_no_edge", int'(o_iagc_status), 1);
        i_sample = 1'b1; tick;
        chk("count0_first_edge", int'(o_iagc_status), 2);
        i_sample = 1'b0; tick;
        i_reset = 1'b0;
        #1;
        chk("midrst_status", int'(o_iagc_status), 0);
        chk("midrst_gain", int'(o_gain), 0);
        chk("midrst_latches", int'(o_reference_latched) + int'(o_error_latched), 0);
        chk("midrst_flags", int'({o_busy, o_done, o_fail}), 0);
        tick;
        i_reset = 1'b1;
        repeat (3) tick;
        chk("post_rst_idle", int'(o_iagc_status), 0);

        // Randomized runs against the model.
        for (int r = 0; r < 12; r++) begin
            int gi, st, mi, tol, cnt;
            gi = int'($urandom_range(0, 255));
            st = int'($urandom_range(0, 40));
            mi = int'($urandom_range(0, 6));
            tol = int'($urandom_range(0, 300));
            cnt = int'($urandom_range(0, 3));
            n_err = 8;
            for (int j = 0; j < 8; j++) err_tab[j] = int'($urandom_range(0, 600));
            model(gi, st, mi, tol, xs, xg, xn);
            run(gi, st, mi, tol, cnt, int'($urandom_range(0, 65535)), xs, xg, xn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
